// File: rtl/timer_pkg.sv
// Shared types and constants for the stopwatch counting engine.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  // Command selected for the current cycle after priority resolution.
  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_CLEAR = 3'd1,
    CMD_LOAD  = 3'd2,
    CMD_START = 3'd3,
    CMD_PAUSE = 3'd4,
    CMD_DIR   = 3'd5
  } cmd_e;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;

  localparam logic [DIGIT_W-1:0]            BCD_MAX   = 4'd9;
  localparam logic [DIGIT_W*NUM_DIGITS-1:0] COUNT_MAX = 16'h9999;

  function automatic logic bcd_valid(input logic [DIGIT_W*NUM_DIGITS-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i*DIGIT_W +: DIGIT_W] > BCD_MAX) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register: sync clear/load, up/down step on enable.
// co flags that an enabled step in the current direction would carry/borrow.
module bcd_digit
  import timer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               en,
  input  logic               up,
  output logic [DIGIT_W-1:0] q,
  output logic               co
);

  logic [DIGIT_W-1:0] q_q, q_d;

  always_comb begin
    co  = up ? (q_q == BCD_MAX) : (q_q == '0);
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      q_d = load_val;
    end else if (en) begin
      if (up) q_d = (q_q == BCD_MAX) ? '0 : q_q + DIGIT_W'(1);
      else    q_d = (q_q == '0) ? BCD_MAX : q_q - DIGIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch counting engine: 100 Hz divider, IDLE/RUN/PAUSE FSM, direction
// flag and a four-digit BCD up/down counter with switch-value load.
module stopwatch_core
  import timer_pkg::*;
#(
  parameter int S100_PERIOD = 1_000_000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start_Pulse,
  input  logic        Pause_Pulse,
  input  logic        Dir_Pulse,
  input  logic        Clear_Pulse,
  input  logic        Load_Pulse,
  input  logic [15:0] Load_Value,
  output logic [15:0] Digits,
  output logic        Led_A,
  output logic        Led_B,
  output logic        Done,
  output state_e      Dbg_State
);

  localparam int DIV_W = (S100_PERIOD > 2) ? $clog2(S100_PERIOD) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(S100_PERIOD - 1);

  state_e             state_q, state_d;
  logic               dir_q, dir_d;
  logic               done_q, done_d;
  logic [DIV_W-1:0]   div_q, div_d;

  cmd_e                    cmd;
  logic                    load_ok;
  logic                    tick;
  logic                    count_tick;
  logic                    down_zero;
  logic                    down_one;
  logic                    digit_en;
  logic [NUM_DIGITS-1:0]   en_chain;
  logic [NUM_DIGITS-1:0]   co;
  logic [DIGIT_W-1:0]      q_arr [NUM_DIGITS];

  // Only the highest-priority pulse is acted on; an out-of-range load is
  // dropped before priority so a lower pulse in the same cycle still counts.
  always_comb begin
    load_ok = bcd_valid(Load_Value);
    cmd     = CMD_NONE;
    if (Clear_Pulse)                 cmd = CMD_CLEAR;
    else if (Load_Pulse && load_ok)  cmd = CMD_LOAD;
    else if (Start_Pulse)            cmd = CMD_START;
    else if (Pause_Pulse)            cmd = CMD_PAUSE;
    else if (Dir_Pulse)              cmd = CMD_DIR;
  end

  assign tick       = (state_q == ST_RUN) && (div_q == DIV_LAST);
  assign count_tick = tick && (cmd == CMD_NONE);
  assign down_zero  = dir_q && (&co);
  assign down_one   = dir_q && (Digits == 16'h0001);
  assign digit_en   = count_tick && !down_zero;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    div_d   = div_q;
    done_d  = 1'b0;
    if (state_q == ST_RUN) div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    case (cmd)
      CMD_CLEAR, CMD_LOAD: begin
        state_d = ST_IDLE;
        div_d   = '0;
      end
      CMD_START: begin
        if (state_q == ST_IDLE) begin
          state_d = ST_RUN;
          div_d   = '0;
        end
      end
      CMD_PAUSE: begin
        if (state_q == ST_RUN)        state_d = ST_PAUSE;
        else if (state_q == ST_PAUSE) state_d = ST_RUN;
      end
      CMD_DIR: dir_d = ~dir_q;
      default: begin
        if (count_tick && (down_zero || down_one)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      div_q   <= div_d;
    end
  end

  // Ripple chain h0 -> h1 -> S0 -> S1; index 0 is the hundredths digit.
  assign en_chain[0] = digit_en;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    if (i > 0) begin : g_chain
      assign en_chain[i] = en_chain[i-1] & co[i-1];
    end
    bcd_digit u_digit (
      .clk      (Clk),
      .rst      (Rst),
      .clr      (cmd == CMD_CLEAR),
      .load     (cmd == CMD_LOAD),
      .load_val (Load_Value[i*DIGIT_W +: DIGIT_W]),
      .en       (en_chain[i]),
      .up       (~dir_q),
      .q        (q_arr[i]),
      .co       (co[i])
    );
    assign Digits[i*DIGIT_W +: DIGIT_W] = q_arr[i];
  end

  assign Led_A     = (state_q == ST_RUN);
  assign Led_B     = dir_q;
  assign Done      = done_q;
  assign Dbg_State = state_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: integer-valued reference model feeding an
// expected queue checked every cycle, plus directed literal checkpoints.
module tb_stopwatch_core;
  import timer_pkg::*;

  localparam int P = 4;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start_Pulse, Pause_Pulse, Dir_Pulse, Clear_Pulse, Load_Pulse;
  logic [15:0] Load_Value;
  logic [15:0] Digits;
  logic        Led_A, Led_B, Done;
  state_e      Dbg_State;

  int total = 0;
  int bad   = 0;
  logic [18:0] exp_q[$];

  int m_cnt, m_div, m_state;
  bit m_dir, m_done;

  stopwatch_core #(.S100_PERIOD(P)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Start_Pulse (Start_Pulse),
    .Pause_Pulse (Pause_Pulse),
    .Dir_Pulse   (Dir_Pulse),
    .Clear_Pulse (Clear_Pulse),
    .Load_Pulse  (Load_Pulse),
    .Load_Value  (Load_Value),
    .Digits      (Digits),
    .Led_A       (Led_A),
    .Led_B       (Led_B),
    .Done        (Done),
    .Dbg_State   (Dbg_State)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  // ---------------- reference model ----------------
  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int from_bcd(input logic [15:0] b);
    return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit all_decimal(input logic [15:0] b);
    bit ok;
    ok = 1;
    for (int k = 0; k < 4; k++) begin
      if (((b >> (4 * k)) & 16'hF) > 16'd9) ok = 0;
    end
    return ok;
  endfunction

  always @(posedge Clk) begin : model
    int cmd;
    bit tk;
    if (Rst) begin
      m_cnt = 0; m_div = 0; m_state = M_IDLE; m_dir = 0; m_done = 0;
    end else begin
      m_done = 0;
      cmd = 0;
      if (Clear_Pulse)                                 cmd = 1;
      else if (Load_Pulse && all_decimal(Load_Value))  cmd = 2;
      else if (Start_Pulse)                            cmd = 3;
      else if (Pause_Pulse)                            cmd = 4;
      else if (Dir_Pulse)                              cmd = 5;
      tk = (m_state == M_RUN) && (m_div == P - 1);
      if (m_state == M_RUN) m_div = (m_div + 1) % P;
      case (cmd)
        1: begin m_cnt = 0; m_state = M_IDLE; m_div = 0; end
        2: begin m_cnt = from_bcd(Load_Value); m_state = M_IDLE; m_div = 0; end
        3: if (m_state == M_IDLE) begin m_state = M_RUN; m_div = 0; end
        4: begin
          if (m_state == M_RUN)        m_state = M_PAUSE;
          else if (m_state == M_PAUSE) m_state = M_RUN;
        end
        5: m_dir = !m_dir;
        default: begin
          if (tk) begin
            if (!m_dir) begin
              m_cnt = (m_cnt + 1) % 10000;
            end else begin
              if (m_cnt > 0) m_cnt = m_cnt - 1;
              if (m_cnt == 0) begin m_state = M_IDLE; m_done = 1; end
            end
          end
        end
      endcase
    end
    exp_q.push_back({m_done, m_dir, (m_state == M_RUN), to_bcd(m_cnt)});
  end

  // ---------------- per-cycle scoreboard ----------------
  always @(negedge Clk) begin
    logic [18:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if ({Done, Led_B, Led_A, Digits} !== e) begin
        bad++;
        $display("FAIL cycle_check t=%0t got done=%b led_b=%b led_a=%b digits=%h want done=%b led_b=%b led_a=%b digits=%h",
                 $time, Done, Led_B, Led_A, Digits, e[18], e[17], e[16], e[15:0]);
      end
    end
  end

  // ---------------- literal checks ----------------
  task automatic check16(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic drive(input bit c, input bit l, input bit s, input bit p, input bit d,
                       input logic [15:0] lv);
    Clear_Pulse = c; Load_Pulse = l; Start_Pulse = s; Pause_Pulse = p; Dir_Pulse = d;
    Load_Value  = lv;
    @(posedge Clk);
    #1;
    Clear_Pulse = 0; Load_Pulse = 0; Start_Pulse = 0; Pause_Pulse = 0; Dir_Pulse = 0;
  endtask

  task automatic do_start();              drive(0, 0, 1, 0, 0, Load_Value); endtask
  task automatic do_pause();              drive(0, 0, 0, 1, 0, Load_Value); endtask
  task automatic do_dir();                drive(0, 0, 0, 0, 1, Load_Value); endtask
  task automatic do_load(input logic [15:0] v); drive(0, 1, 0, 0, 0, v);     endtask

  // ---------------- directed sequence ----------------
  initial begin
    Rst = 1;
    Start_Pulse = 0; Pause_Pulse = 0; Dir_Pulse = 0; Clear_Pulse = 0; Load_Pulse = 0;
    Load_Value = 16'h0000;
    wait_cycles(2);
    Rst = 0;
    check16("reset_digits", Digits, 16'h0000);
    check1("reset_led_a", Led_A, 1'b0);
    check1("reset_led_b", Led_B, 1'b0);
    check1("reset_done", Done, 1'b0);
    check16("reset_state", 16'(Dbg_State), 16'(ST_IDLE));

    // start near cycle 10, count up
    wait_cycles(7);
    do_start();
    wait_cycles(4);
    check16("up_first_tick", Digits, 16'h0001);
    check1("up_led_a", Led_A, 1'b1);
    check1("up_led_b", Led_B, 1'b0);
    wait_cycles(8);
    check16("up_third_tick", Digits, 16'h0003);
    wait_cycles(8);
    check16("up_fifth_tick", Digits, 16'h0005);

    // pause holds, resume finishes the remaining divider count
    do_pause();
    check1("pause_led_a", Led_A, 1'b0);
    wait_cycles(40);
    check16("pause_hold", Digits, 16'h0005);
    check1("pause_hold_led_a", Led_A, 1'b0);
    do_pause();
    check1("resume_led_a", Led_A, 1'b1);
    wait_cycles(2);
    check16("resume_not_yet", Digits, 16'h0005);
    wait_cycles(1);
    check16("resume_tick", Digits, 16'h0006);

    // load, count down, reach zero with Done
    do_load(16'h0803);
    check16("load_0803", Digits, 16'h0803);
    check1("load_idle", Led_A, 1'b0);
    do_dir();
    check1("dir_down", Led_B, 1'b1);
    do_start();
    wait_cycles(4);
    check16("down_0802", Digits, 16'h0802);
    do_load(16'h0002);
    check16("load_0002", Digits, 16'h0002);
    do_start();
    wait_cycles(4);
    check16("down_0001", Digits, 16'h0001);
    wait_cycles(4);
    check16("down_0000", Digits, 16'h0000);
    check1("down_done", Done, 1'b1);
    check1("down_idle", Led_A, 1'b0);
    wait_cycles(1);
    check1("done_one_cycle", Done, 1'b0);

    // up-count wrap and illegal load
    do_dir();
    check1("dir_up", Led_B, 1'b0);
    do_load(COUNT_MAX);
    do_start();
    wait_cycles(4);
    check16("wrap_0000", Digits, 16'h0000);
    check1("wrap_still_run", Led_A, 1'b1);
    do_load(16'h0A03);
    check16("bad_load_ignored", Digits, 16'h0000);
    check1("bad_load_run", Led_A, 1'b1);

    // clear beats load
    do_load(16'h0042);
    check16("load_0042", Digits, 16'h0042);
    drive(1, 1, 0, 0, 0, 16'h1234);
    check16("clear_beats_load", Digits, 16'h0000);
    check1("clear_idle", Led_A, 1'b0);

    // start coinciding with a tick discards the tick
    do_start();
    wait_cycles(3);
    do_start();
    check16("start_on_tick", Digits, 16'h0000);
    wait_cycles(3);
    check16("after_discard", Digits, 16'h0000);
    wait_cycles(1);
    check16("next_tick", Digits, 16'h0001);

    // reset while running down
    do_dir();
    wait_cycles(1);
    Rst = 1;
    wait_cycles(1);
    Rst = 0;
    check16("rst_digits", Digits, 16'h0000);
    check1("rst_led_a", Led_A, 1'b0);
    check1("rst_led_b", Led_B, 1'b0);
    check1("rst_done", Done, 1'b0);
    do_start();
    wait_cycles(4);
    check16("rst_dir_up", Digits, 16'h0001);

    wait_cycles(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog sequence did not complete by t=%0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Counting engine of the digital timer: consumes the single-cycle command pulses from the debounce/edge stage and produces a 4-digit BCD value (SS.hh, 00.00–99.99) plus status LEDs for the seven-segment scan stage. Contains its own 100 Hz tick divider, a run/pause/idle FSM, an up/down direction flag and a four-digit BCD up/down counter with switch-value load.

## Interface
- S100_PERIOD, default 1_000_000: Clk cycles per hundredth-second tick; legal range ≥ 2.
- Clk  in  1  system clock; all logic on rising edge.
- Rst  in  1  reset, synchronous, active-high.
- Start_Pulse  in  1  1-cycle pulse (centre button): start counting.
- Pause_Pulse  in  1  1-cycle pulse (up button): toggle RUN/PAUSE.
- Dir_Pulse  in  1  1-cycle pulse (left button): toggle count direction.
- Clear_Pulse  in  1  1-cycle pulse (down button): zero the count.
- Load_Pulse  in  1  1-cycle pulse (right button): load Load_Value.
- Load_Value  in  16  four BCD digits {S1,S0,h1,h0} from Switch[15:0].
- Digits  out  16  current count, BCD {S1,S0,h1,h0}.
- Led_A  out  1  1 while state == RUN.
- Led_B  out  1  1 while direction == down.
- Done  out  1  1-cycle pulse when a down-count reaches 00.00.

## Operation
- States: IDLE, RUN, PAUSE. Direction flag: UP (0) / DOWN (1).
- Commands, evaluated every cycle, at most one acted on, priority Clear > Load > Start > Pause > Dir:
  - Clear: count ← 0000, state ← IDLE; direction unchanged.
  - Load: if all four nibbles ≤ 9, count ← Load_Value and state ← IDLE; otherwise the pulse is ignored entirely.
  - Start: IDLE → RUN; no effect in RUN or PAUSE.
  - Pause: RUN → PAUSE, PAUSE → RUN; no effect in IDLE.
  - Dir: toggle direction in any state.
- Tick divider: counter 0..S100_PERIOD−1 that advances only in RUN and holds its value in PAUSE. It is zeroed by Rst, Clear, a valid Load, and Start. Tick is asserted when the divider equals S100_PERIOD−1 in RUN.
- On a tick with no command acted on in the same cycle:
  - UP: BCD increment with ripple carry h0→h1→S0→S1. At 99.99 the count wraps to 00.00 and keeps running.
  - DOWN: BCD decrement with borrow. At 00.01 the count goes to 00.00, state ← IDLE, and Done pulses. A tick that arrives while the count is already 00.00 in DOWN is not counted; state ← IDLE and Done pulses.
- A command and a tick in the same cycle: the command wins and that tick is discarded.

## Timing
- Reset values: Digits = 16'h0000, Led_A = 0, Led_B = 0, Done = 0, state IDLE, direction UP, divider 0.
- All outputs are registered. A command pulse at edge N is visible on Digits/Led_A/Led_B after edge N+1 (latency 1).
- After Start at edge N, the first increment appears S100_PERIOD cycles later. Every subsequent increment follows S100_PERIOD cycles after the previous one.
- Done is high for exactly one cycle, in the same cycle that Digits first shows 0000.
- Rst asserted mid-count overrides all commands and ticks on that edge.

## Structure
- Package timer_pkg holds:
  - the state encoding (IDLE/RUN/PAUSE);
  - the BCD digit width (4) and digit count (4);
  - constants BCD_MAX = 4'd9 and COUNT_MAX = 16'h9999.
- Sub-module bcd_digit: a single BCD digit register with up/down, enable, synchronous load/clear, and carry/borrow out. stopwatch_core instantiates it four times as a ripple chain.
- FSM, divider and command priority logic live in stopwatch_core. Estimated size: ~200 lines.

## Test plan
Run every scenario with S100_PERIOD = 4.
- Reset → Start at cycle 10 → Digits = 0001 after 4 cycles and 0003 after 12 cycles; Led_A = 1, Led_B = 0.
- Running at 0005 → Pause → Digits holds 0005 for 40 cycles with Led_A = 0 → Pause → the next increment arrives exactly after the remaining divider count.
- Load 16'h0803 → Digits = 0803 with state IDLE → Dir → Start → decrements to 0802 → force Load 0002 then Start → 0001, 0000, Done pulses once, Led_A = 0.
- Load 16'h9999 in UP → Start → next tick gives 0000 with Led_A still 1. Load 16'h0A03 → ignored, Digits unchanged.
- Clear and Load in the same cycle → Digits = 0000. Start coinciding with a tick → no increment that cycle.
- Rst asserted while RUN and DOWN → next cycle all outputs = 0, direction UP.
